// File: rtl/getir_pkg.sv
// -----------------------------------------------------------------------------
// getir_pkg
//   Shared definitions for the instruction-fetch block (fmax_getir):
//     durum_t      2-bit FSM state encoding exposed on the durum port
//     NOP_KOMUT    default instruction driven whenever no valid fetch exists
//     adres_hatali fetch-address fault check (misaligned or out of range)
// -----------------------------------------------------------------------------
package getir_pkg;

  typedef enum logic [1:0] {
    BOS   = 2'd0,
    CALIS = 2'd1,
    YUKLE = 2'd2,
    DUR   = 2'd3
  } durum_t;

  localparam logic [31:0] NOP_KOMUT = 32'h0000_0013;

  // off is the byte offset from the memory base, already wrapped to 32 bits,
  // so a pc below the base shows up as a huge offset and trips the range test.
  function automatic logic adres_hatali(input logic [1:0]  pc_lo,
                                        input logic [31:0] off,
                                        input logic [31:0] lim_bytes);
    return (pc_lo != 2'b00) || (off >= lim_bytes);
  endfunction

endpackage

// File: rtl/komut_bellegi.sv
// -----------------------------------------------------------------------------
// komut_bellegi
//   Instruction memory: WORDS x 32 bits, one synchronous write port and one
//   synchronous read port. Contents and read register are never reset, so the
//   program survives a core reset.
//   Ports:
//     clk_i     clock
//     we_i      write enable
//     wa_i      write word index
//     wd_i      write data
//     re_i      read enable (read register holds its value when low)
//     ra_i      read word index
//     rd_o      registered read data, valid one cycle after re_i
// -----------------------------------------------------------------------------
module komut_bellegi #(
  parameter int WORDS = 256,
  parameter int IDX_W = $clog2(WORDS)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [IDX_W-1:0] wa_i,
  input  logic [31:0]      wd_i,
  input  logic             re_i,
  input  logic [IDX_W-1:0] ra_i,
  output logic [31:0]      rd_o
);

  logic [31:0] mem_q [WORDS];
  logic [31:0] rd_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[wa_i] <= wd_i;
    end
    if (re_i) begin
      rd_q <= mem_q[ra_i];
    end
  end

  assign rd_o = rd_q;

endmodule

// File: rtl/fmax_getir.sv
// -----------------------------------------------------------------------------
// fmax_getir
//   Instruction-fetch end of the core boundary. Takes the registered pc and
//   hata from the core and returns komut from on-chip instruction memory with
//   one cycle of read latency. Provides a program-load write port, checks every
//   fetch address, and halts fetching on core or address faults.
//   Ports:
//     clk         clock, all state on rising edge
//     reset       asynchronous active-low reset
//     pc          byte fetch address from the core
//     hata        core error flag, sampled every cycle
//     yukle_en    program-load write enable
//     yukle_adr   program-load word index
//     yukle_veri  program-load data word
//     komut       fetched instruction (NOP when no valid fetch)
//     getir_hata  sticky fetch-address fault
//     durum       FSM state (durum_t encoding)
//     sayac       saturating count of valid fetches
// -----------------------------------------------------------------------------
module fmax_getir
  import getir_pkg::*;
#(
  parameter int          MEM_WORDS = 256,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter logic [31:0] NOP       = NOP_KOMUT
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [31:0]                  pc,
  input  logic                         hata,
  input  logic                         yukle_en,
  input  logic [$clog2(MEM_WORDS)-1:0] yukle_adr,
  input  logic [31:0]                  yukle_veri,
  output logic [31:0]                  komut,
  output logic                         getir_hata,
  output logic [1:0]                   durum,
  output logic [31:0]                  sayac
);

  localparam int          IDX_W = $clog2(MEM_WORDS);
  localparam logic [31:0] LIM   = 32'(MEM_WORDS * 4);

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  durum_t           state_q;
  logic             vld_q;
  logic             getir_hata_q;
  logic [31:0]      sayac_q;
  logic [31:0]      sayac_d;

  logic [31:0]      off;
  logic             fault;
  logic [IDX_W-1:0] idx;
  logic             rd_en;
  logic             wr_en;
  logic [31:0]      rd_data;

  assign off     = pc - BASE_ADDR;
  assign fault   = adres_hatali(pc[1:0], off, LIM);
  assign idx     = off[IDX_W+1:2];
  assign sayac_d = sat_inc(sayac_q);

  // A read is only launched when the fetch will actually be delivered, so the
  // read register keeps its last good word otherwise (masked by vld_q anyway).
  assign rd_en = (state_q == CALIS) && !hata && !fault && !yukle_en;
  assign wr_en = (state_q == YUKLE) && yukle_en;

  komut_bellegi #(
    .WORDS (MEM_WORDS),
    .IDX_W (IDX_W)
  ) u_bellek (
    .clk_i (clk),
    .we_i  (wr_en),
    .wa_i  (yukle_adr),
    .wd_i  (yukle_veri),
    .re_i  (rd_en),
    .ra_i  (idx),
    .rd_o  (rd_data)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= BOS;
      vld_q        <= 1'b0;
      getir_hata_q <= 1'b0;
      sayac_q      <= 32'd0;
    end else begin
      case (state_q)
        BOS: begin
          vld_q   <= 1'b0;
          state_q <= yukle_en ? YUKLE : CALIS;
        end
        CALIS: begin
          // Core error and address fault take priority over a load request.
          if (hata || fault) begin
            state_q <= DUR;
            vld_q   <= 1'b0;
            if (fault) begin
              getir_hata_q <= 1'b1;
            end
          end else if (yukle_en) begin
            state_q <= YUKLE;
            vld_q   <= 1'b0;
          end else begin
            vld_q   <= 1'b1;
            sayac_q <= sayac_d;
          end
        end
        YUKLE: begin
          vld_q <= 1'b0;
          if (!yukle_en) begin
            state_q <= BOS;
          end
        end
        DUR: begin
          vld_q <= 1'b0;
        end
        default: begin
          state_q <= BOS;
          vld_q   <= 1'b0;
        end
      endcase
    end
  end

  // The read register is unreset memory output; vld_q (reset) gates it so
  // komut is NOP out of reset and in every cycle without a delivered fetch.
  assign komut      = vld_q ? rd_data : NOP;
  assign getir_hata = getir_hata_q;
  assign durum      = state_q;
  assign sayac      = sayac_q;

endmodule
